l2_mem_xbar: RTL and testbench

//  Parametrised NumIn x NumOut crossbar from request/grant memory ports (PEs, DMA) to L2 SRAM regions.

---
 rtl/l2_mem_xbar_if.sv | 55 +++++
 rtl/l2_mem_xbar.sv | 183 ++++++++++++++++++
 tb/tb_l2_mem_xbar.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_xbar_if.sv
// Bus bundle for the L2 memory crossbar: requester-side request/response ports,
// region-side request ports, address rules and the decode-error counter.
interface l2_mem_xbar_if #(
    parameter int unsigned NumIn       = 2,
    parameter int unsigned NumOut      = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned ErrCntWidth = 16
);
    localparam int unsigned BeWidth = DataWidth / 8;

    // Handshake: a request is transferred in the cycle where req and gnt are both high.
    // A requester that sees gnt low keeps req and its payload stable until granted.
    logic                          prio_mode_i;
    logic [NumOut*AddrWidth-1:0]   rule_start_i;
    logic [NumOut*AddrWidth-1:0]   rule_end_i;

    logic [NumIn-1:0]              in_req_i;
    logic [NumIn-1:0]              in_gnt_o;
    logic [NumIn*AddrWidth-1:0]    in_addr_i;
    logic [NumIn-1:0]              in_we_i;
    logic [NumIn*DataWidth-1:0]    in_wdata_i;
    logic [NumIn*BeWidth-1:0]      in_be_i;
    logic [NumIn-1:0]              in_rvalid_o;
    logic [NumIn*DataWidth-1:0]    in_rdata_o;
    logic [NumIn-1:0]              in_err_o;

    logic [NumOut-1:0]             out_req_o;
    logic [NumOut-1:0]             out_gnt_i;
    logic [NumOut*AddrWidth-1:0]   out_addr_o;
    logic [NumOut-1:0]             out_we_o;
    logic [NumOut*DataWidth-1:0]   out_wdata_o;
    logic [NumOut*BeWidth-1:0]     out_be_o;
    logic [NumOut*DataWidth-1:0]   out_rdata_i;

    logic [ErrCntWidth-1:0]        err_cnt_o;

    modport slave (
        input  prio_mode_i, rule_start_i, rule_end_i,
        input  in_req_i, in_addr_i, in_we_i, in_wdata_i, in_be_i,
        output in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
        output out_req_o, out_addr_o, out_we_o, out_wdata_o, out_be_o,
        input  out_gnt_i, out_rdata_i,
        output err_cnt_o
    );

    modport master (
        output prio_mode_i, rule_start_i, rule_end_i,
        output in_req_i, in_addr_i, in_we_i, in_wdata_i, in_be_i,
        input  in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
        input  out_req_o, out_addr_o, out_we_o, out_wdata_o, out_be_o,
        output out_gnt_i, out_rdata_i,
        input  err_cnt_o
    );
endinterface

// File: rtl/l2_mem_xbar.sv
// NumIn x NumOut request/grant crossbar into L2 regions with programmable address
// rules, per-region round-robin or fixed-priority arbitration and in-order responses.
module l2_mem_xbar #(
    parameter int unsigned NumIn       = 2,
    parameter int unsigned NumOut      = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned RespLatency = 1,
    parameter int unsigned ErrCntWidth = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    l2_mem_xbar_if.slave bus
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned InIdxW  = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned OutIdxW = (NumOut > 1) ? $clog2(NumOut) : 1;

    typedef struct packed {
        logic               valid;
        logic               err;
        logic               we;
        logic [OutIdxW-1:0] idx;
    } resp_t;

    logic [NumIn-1:0]       dec_hit;
    logic [OutIdxW-1:0]     dec_idx   [NumIn];
    logic [NumIn-1:0]       cand      [NumOut];
    logic [NumOut-1:0]      win_any;
    logic [InIdxW-1:0]      win_idx   [NumOut];
    logic [InIdxW-1:0]      rr_ptr_q  [NumOut];
    logic [InIdxW-1:0]      rr_ptr_d  [NumOut];
    logic [NumIn-1:0]       gnt;
    logic [NumIn-1:0]       err_gnt;
    resp_t                  pipe_q    [NumIn][RespLatency];
    resp_t                  pipe_d    [NumIn][RespLatency];
    resp_t                  head      [NumIn];
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic [ErrCntWidth-1:0] err_cnt_d;

    // Scanning from the top down lets the lowest matching region overwrite the others.
    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            dec_hit[i] = 1'b0;
            dec_idx[i] = '0;
            for (int r = int'(NumOut) - 1; r >= 0; r--) begin
                if ((bus.rule_start_i[r*AddrWidth +: AddrWidth] <= bus.in_addr_i[i*AddrWidth +: AddrWidth]) &&
                    (bus.in_addr_i[i*AddrWidth +: AddrWidth] < bus.rule_end_i[r*AddrWidth +: AddrWidth])) begin
                    dec_hit[i] = 1'b1;
                    dec_idx[i] = OutIdxW'(r);
                end
            end
        end
    end

    // First pass finds a requester at or above the pointer, second pass wraps to the lowest.
    always_comb begin
        for (int r = 0; r < NumOut; r++) begin
            win_any[r] = 1'b0;
            win_idx[r] = '0;
            for (int i = 0; i < NumIn; i++) begin
                cand[r][i] = bus.in_req_i[i] && dec_hit[i] && (dec_idx[i] == OutIdxW'(r));
            end
            for (int i = 0; i < NumIn; i++) begin
                if (!win_any[r] && cand[r][i] && (bus.prio_mode_i || (InIdxW'(i) >= rr_ptr_q[r]))) begin
                    win_any[r] = 1'b1;
                    win_idx[r] = InIdxW'(i);
                end
            end
            for (int i = 0; i < NumIn; i++) begin
                if (!win_any[r] && cand[r][i]) begin
                    win_any[r] = 1'b1;
                    win_idx[r] = InIdxW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt             = '0;
        err_gnt         = '0;
        bus.out_req_o   = '0;
        bus.out_addr_o  = '0;
        bus.out_we_o    = '0;
        bus.out_wdata_o = '0;
        bus.out_be_o    = '0;
        for (int r = 0; r < NumOut; r++) begin
            if (win_any[r]) begin
                bus.out_req_o[r]                          = 1'b1;
                bus.out_addr_o[r*AddrWidth +: AddrWidth]  = bus.in_addr_i[win_idx[r]*AddrWidth +: AddrWidth];
                bus.out_we_o[r]                           = bus.in_we_i[win_idx[r]];
                bus.out_wdata_o[r*DataWidth +: DataWidth] = bus.in_wdata_i[win_idx[r]*DataWidth +: DataWidth];
                bus.out_be_o[r*BeWidth +: BeWidth]        = bus.in_be_i[win_idx[r]*BeWidth +: BeWidth];
                if (bus.out_gnt_i[r]) begin
                    gnt[win_idx[r]] = 1'b1;
                end
            end
        end
        // Unmapped requests are accepted locally and answered with an error.
        for (int i = 0; i < NumIn; i++) begin
            if (bus.in_req_i[i] && !dec_hit[i]) begin
                gnt[i]     = 1'b1;
                err_gnt[i] = 1'b1;
            end
        end
        if (rst_i) begin
            gnt           = '0;
            err_gnt       = '0;
            bus.out_req_o = '0;
        end
        bus.in_gnt_o = gnt;
    end

    always_comb begin
        for (int r = 0; r < NumOut; r++) begin
            rr_ptr_d[r] = rr_ptr_q[r];
            if (!bus.prio_mode_i && win_any[r] && bus.out_gnt_i[r]) begin
                rr_ptr_d[r] = (win_idx[r] == InIdxW'(NumIn - 1)) ? '0 : win_idx[r] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            pipe_d[i][0].valid = gnt[i];
            pipe_d[i][0].err   = err_gnt[i];
            pipe_d[i][0].we    = bus.in_we_i[i];
            pipe_d[i][0].idx   = dec_idx[i];
            for (int s = 1; s < RespLatency; s++) begin
                pipe_d[i][s] = pipe_q[i][s-1];
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        for (int i = 0; i < NumIn; i++) begin
            if (err_gnt[i] && (err_cnt_d != '1)) begin
                err_cnt_d = err_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIn; i++) begin
                for (int s = 0; s < RespLatency; s++) begin
                    pipe_q[i][s] <= '0;
                end
            end
            for (int r = 0; r < NumOut; r++) begin
                rr_ptr_q[r] <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                for (int s = 0; s < RespLatency; s++) begin
                    pipe_q[i][s] <= pipe_d[i][s];
                end
            end
            for (int r = 0; r < NumOut; r++) begin
                rr_ptr_q[r] <= rr_ptr_d[r];
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    // Responses are suppressed while reset is held so in-flight work is never delivered.
    always_comb begin
        bus.in_rvalid_o = '0;
        bus.in_err_o    = '0;
        bus.in_rdata_o  = '0;
        for (int i = 0; i < NumIn; i++) begin
            head[i]            = pipe_q[i][RespLatency-1];
            bus.in_rvalid_o[i] = head[i].valid && !rst_i;
            bus.in_err_o[i]    = head[i].valid && head[i].err && !rst_i;
            if (head[i].valid && !head[i].err && !head[i].we && !rst_i) begin
                bus.in_rdata_o[i*DataWidth +: DataWidth] = bus.out_rdata_i[head[i].idx*DataWidth +: DataWidth];
            end
        end
        bus.err_cnt_o = err_cnt_q;
    end
endmodule

// File: tb/tb_l2_mem_xbar.sv
// Bench for l2_mem_xbar: two instances (latency 1 and 3) share one stimulus stream and
// are checked every cycle against a queue-based reference of grants and responses.
module tb_l2_mem_xbar;
    localparam int NI          = 2;
    localparam int NO          = 2;
    localparam int AW          = 32;
    localparam int DW          = 64;
    localparam int BW          = DW / 8;
    localparam int CW          = 16;
    localparam int SAT_CYCLES  = 32773;
    localparam int RAND_CYCLES = 3000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic          prio;
    logic [AW-1:0] rs    [NO];
    logic [AW-1:0] rend  [NO];
    logic [NI-1:0] req;
    logic [NI-1:0] we;
    logic [AW-1:0] addr  [NI];
    logic [DW-1:0] wdata [NI];
    logic [BW-1:0] be    [NI];
    logic [NO-1:0] ogt;
    logic [DW-1:0] ord   [NO];

    logic [NO*AW-1:0] rs_f, re_f;
    logic [NI*AW-1:0] addr_f;
    logic [NI*DW-1:0] wdata_f;
    logic [NI*BW-1:0] be_f;
    logic [NO*DW-1:0] ord_f;

    always_comb begin
        for (int r = 0; r < NO; r++) begin
            rs_f[r*AW +: AW]  = rs[r];
            re_f[r*AW +: AW]  = rend[r];
            ord_f[r*DW +: DW] = ord[r];
        end
        for (int i = 0; i < NI; i++) begin
            addr_f[i*AW +: AW]  = addr[i];
            wdata_f[i*DW +: DW] = wdata[i];
            be_f[i*BW +: BW]    = be[i];
        end
    end

    // ---------------- DUTs ----------------
    l2_mem_xbar_if #(.NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .ErrCntWidth(CW)) bus [2] ();

    l2_mem_xbar #(.NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .RespLatency(1), .ErrCntWidth(CW))
        dut1 (.clk_i(clk), .rst_i(rst), .bus(bus[0]));
    l2_mem_xbar #(.NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .RespLatency(3), .ErrCntWidth(CW))
        dut3 (.clk_i(clk), .rst_i(rst), .bus(bus[1]));

    logic [NI-1:0]    o_gnt   [2];
    logic [NI-1:0]    o_rv    [2];
    logic [NI-1:0]    o_err   [2];
    logic [NI*DW-1:0] o_rdata [2];
    logic [NO-1:0]    o_req   [2];
    logic [NO-1:0]    o_we    [2];
    logic [NO*AW-1:0] o_addr  [2];
    logic [NO*DW-1:0] o_wdata [2];
    logic [NO*BW-1:0] o_be    [2];
    logic [CW-1:0]    o_cnt   [2];

    for (genvar g = 0; g < 2; g++) begin : g_bus
        assign bus[g].prio_mode_i  = prio;
        assign bus[g].rule_start_i = rs_f;
        assign bus[g].rule_end_i   = re_f;
        assign bus[g].in_req_i     = req;
        assign bus[g].in_addr_i    = addr_f;
        assign bus[g].in_we_i      = we;
        assign bus[g].in_wdata_i   = wdata_f;
        assign bus[g].in_be_i      = be_f;
        assign bus[g].out_gnt_i    = ogt;
        assign bus[g].out_rdata_i  = ord_f;
        assign o_gnt[g]   = bus[g].in_gnt_o;
        assign o_rv[g]    = bus[g].in_rvalid_o;
        assign o_err[g]   = bus[g].in_err_o;
        assign o_rdata[g] = bus[g].in_rdata_o;
        assign o_req[g]   = bus[g].out_req_o;
        assign o_we[g]    = bus[g].out_we_o;
        assign o_addr[g]  = bus[g].out_addr_o;
        assign o_wdata[g] = bus[g].out_wdata_o;
        assign o_be[g]    = bus[g].out_be_o;
        assign o_cnt[g]   = bus[g].err_cnt_o;
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int due;
        bit err;
        bit we;
        int rg;
    } exp_t;

    exp_t          exp_q [2*NI][$];
    int            ptr   [NO];
    int unsigned   ecnt;
    int            cyc;
    logic [NI-1:0] last_gnt;
    int            n_cmp;
    int            n_err;
    string         dn [2] = '{"lat1", "lat3"};

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < 2*NI; q++) exp_q[q].delete();
        for (int r = 0; r < NO; r++) ptr[r] = 0;
        ecnt = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model past the edge.
    task automatic cycle();
        int            rg [NI];
        int            win;
        int            idx;
        logic [NI-1:0] eg;
        logic [NI-1:0] egerr;
        logic [NO-1:0] eo;
        logic          ev;
        logic          ee;
        logic [DW-1:0] ed;
        exp_t          e;
        #3;
        for (int i = 0; i < NI; i++) begin
            rg[i] = -1;
            for (int r = 0; r < NO; r++) begin
                if (rs[r] <= addr[i] && addr[i] < rend[r]) begin
                    rg[i] = r;
                    break;
                end
            end
        end
        eg = '0; egerr = '0; eo = '0;
        for (int r = 0; r < NO; r++) begin
            win = -1;
            for (int k = 0; k < NI; k++) begin
                idx = prio ? k : (ptr[r] + k) % NI;
                if (req[idx] && rg[idx] == r) begin
                    win = idx;
                    break;
                end
            end
            if (win >= 0 && !rst) begin
                eo[r] = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    check({dn[d], " out_addr"},  DW'(o_addr[d][r*AW +: AW]), DW'(addr[win]));
                    check({dn[d], " out_we"},    DW'(o_we[d][r]), DW'(we[win]));
                    check({dn[d], " out_wdata"}, o_wdata[d][r*DW +: DW], wdata[win]);
                    check({dn[d], " out_be"},    DW'(o_be[d][r*BW +: BW]), DW'(be[win]));
                end
                if (ogt[r]) begin
                    eg[win] = 1'b1;
                    if (!prio) ptr[r] = (win + 1) % NI;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (req[i] && rg[i] < 0 && !rst) begin
                eg[i]    = 1'b1;
                egerr[i] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check({dn[d], " in_gnt"},  DW'(o_gnt[d]), DW'(eg));
            check({dn[d], " out_req"}, DW'(o_req[d]), DW'(eo));
            for (int i = 0; i < NI; i++) begin
                ev = 1'b0; ee = 1'b0; ed = '0;
                if (!rst && exp_q[d*NI+i].size() > 0 && exp_q[d*NI+i][0].due == cyc) begin
                    e  = exp_q[d*NI+i].pop_front();
                    ev = 1'b1;
                    ee = e.err;
                    ed = (e.err || e.we) ? '0 : ord[e.rg];
                end
                check({dn[d], " rvalid"}, DW'(o_rv[d][i]), DW'(ev));
                check({dn[d], " err"},    DW'(o_err[d][i]), DW'(ee));
                check({dn[d], " rdata"},  o_rdata[d][i*DW +: DW], ed);
            end
            if (!rst) check({dn[d], " err_cnt"}, DW'(o_cnt[d]), DW'(ecnt));
        end
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (eg[i]) begin
                    e.err = egerr[i];
                    e.we  = we[i];
                    e.rg  = (rg[i] < 0) ? 0 : rg[i];
                    for (int d = 0; d < 2; d++) begin
                        e.due = cyc + lat_of(d);
                        exp_q[d*NI+i].push_back(e);
                    end
                    if (egerr[i] && ecnt < (32'd1 << CW) - 1) ecnt++;
                end
            end
        end
        last_gnt = eg;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_default_rules();
        rs[0] = 32'h0000; rend[0] = 32'h1000;
        rs[1] = 32'h1000; rend[1] = 32'h2000;
    endtask

    task automatic drive_req(input int i, input logic [AW-1:0] a, input logic w);
        req[i]   = 1'b1;
        addr[i]  = a;
        we[i]    = w;
        wdata[i] = {$urandom, $urandom};
        be[i]    = BW'($urandom);
    endtask

    task automatic randomize_rules();
        if ($urandom_range(0, 1) == 0) begin
            set_default_rules();
        end else begin
            for (int r = 0; r < NO; r++) begin
                rs[r]   = $urandom_range(0, 'h3000);
                rend[r] = $urandom_range(0, 'h3FFF);
            end
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, NO - 1);
        case ($urandom_range(0, 4))
            0:       return rs[r];
            1:       return rend[r] - 1;
            2:       return rend[r];
            3:       return rs[r] + $urandom_range(0, 15);
            default: return $urandom_range(0, 'h3FFF);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_gnt = '0;
        prio = 1'b0; ogt = '1; req = '0; we = '0;
        set_default_rules();
        for (int i = 0; i < NI; i++) begin addr[i] = '0; wdata[i] = '0; be[i] = '0; end
        for (int r = 0; r < NO; r++) ord[r] = '0;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // single read through region 0
        ord[0] = 64'hAA; ord[1] = 64'h55;
        drive_req(0, 32'h10, 1'b0);
        cycle();
        req = '0;
        cycle();

        // contention on region 0: round-robin, then fixed priority
        drive_req(0, 32'h20, 1'b0);
        drive_req(1, 32'h40, 1'b1);
        repeat (6) cycle();
        prio = 1'b1;
        repeat (4) cycle();
        prio = 1'b0;
        req = '0;
        cycle();

        // unmapped access from in1
        drive_req(1, 32'h3000, 1'b0);
        cycle();
        req = '0;
        cycle();
        check("err_cnt after one error", DW'(o_cnt[0]), DW'(16'd1));

        // region 1 stalls for three cycles
        ogt[1] = 1'b0;
        drive_req(0, 32'h1234, 1'b0);
        repeat (3) cycle();
        ogt[1] = 1'b1;
        cycle();
        req = '0;
        repeat (3) cycle();

        // back-to-back region 0, region 1, unmapped
        ord[0] = 64'h1111_2222_3333_4444; ord[1] = 64'h5555_6666_7777_8888;
        drive_req(0, 32'h10, 1'b0);   cycle();
        drive_req(0, 32'h1010, 1'b0); cycle();
        drive_req(0, 32'h3000, 1'b0); cycle();
        req = '0;
        repeat (5) cycle();

        // randomized traffic, rules, priority mode, region stalls and occasional resets
        for (int n = 0; n < RAND_CYCLES; n++) begin
            if ($urandom_range(0, 49) == 0) randomize_rules();
            if ($urandom_range(0, 99) == 0) prio = ~prio;
            for (int r = 0; r < NO; r++) begin
                ogt[r] = ($urandom_range(0, 3) != 0);
                ord[r] = {$urandom, $urandom};
            end
            for (int i = 0; i < NI; i++) begin
                if (!(req[i] && !last_gnt[i])) begin
                    if ($urandom_range(0, 3) != 0) drive_req(i, pick_addr(), 1'($urandom_range(0, 1)));
                    else req[i] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; prio = 1'b0; ogt = '1; req = '0;
        set_default_rules();
        repeat (5) cycle();

        // saturate the error counter: two errored grants per cycle
        drive_req(0, 32'h3000, 1'b0);
        drive_req(1, 32'h3000, 1'b1);
        repeat (SAT_CYCLES) cycle();
        req = '0;
        repeat (4) cycle();
        check("err_cnt saturated lat1", DW'(o_cnt[0]), DW'(16'hFFFF));
        check("err_cnt saturated lat3", DW'(o_cnt[1]), DW'(16'hFFFF));

        // reset with reads in flight; the region 0 handshake moves its pointer to 1 first
        ord[0] = 64'hDEAD; ord[1] = 64'hBEEF;
        drive_req(0, 32'h10, 1'b0);
        drive_req(1, 32'h1010, 1'b0);
        cycle();
        req = '0;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (4) cycle();
        check("err_cnt after reset lat1", DW'(o_cnt[0]), DW'(16'd0));
        check("err_cnt after reset lat3", DW'(o_cnt[1]), DW'(16'd0));
        drive_req(0, 32'h80, 1'b0);
        drive_req(1, 32'h90, 1'b0);
        #1;
        check("rr restart lat1", DW'(o_gnt[0]), DW'(2'b01));
        check("rr restart lat3", DW'(o_gnt[1]), DW'(2'b01));
        cycle();
        req = '0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
